// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter in front of a shared UART transmitter
module uart_tx_arbiter #(
  parameter int                    NUM_REQ      = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] EOP_CHAR     = 8'h0A,
  parameter int                    MAX_PKT_LEN  = 64,
  parameter int                    IDLE_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_PKT_LEN + 1);
  localparam int ICW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [PW-1:0]           last_q, last_d;
  logic [BCW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [ICW-1:0]          idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic                    reg_free;
  logic                    gnt_valid;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic                    accept;
  logic                    win_found;
  logic [PW-1:0]           win_idx;

  assign reg_free  = !tx_valid_q || tx_ready;
  assign gnt_valid = |(req_valid & grant_q);
  assign accept    = (state_q == LOCKED) && gnt_valid && reg_free;
  assign req_ready = ((state_q == LOCKED) && reg_free) ? grant_q : '0;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant    = grant_q;
  assign busy     = (state_q == LOCKED);

  // Select the byte of the current owner; grant is one-hot so an OR-mux suffices.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) gnt_data = gnt_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first valid requester after the last winner, wrapping around.
  always_comb begin
    logic [PW-1:0] idx;
    win_found = 1'b0;
    win_idx   = last_q;
    idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PW'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, byte forwarding and release conditions in LOCKED.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q && !tx_ready;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = LOCKED;
          grant_d    = NUM_REQ'(1) << win_idx;
          last_d     = win_idx;
          byte_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = gnt_data;
          byte_cnt_d = byte_cnt_q + BCW'(1);
          idle_cnt_d = '0;
          if ((gnt_data == EOP_CHAR) || (byte_cnt_q + BCW'(1) == BCW'(MAX_PKT_LEN))) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!gnt_valid) begin
          if (idle_cnt_q == ICW'(IDLE_TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + ICW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, counters and output register; reset drops any held byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= PW'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int         NREQ = 4;
  localparam int         DW   = 8;
  localparam logic [7:0] EOP  = 8'h0A;
  localparam int         MAXL = 64;
  localparam int         TO   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .DATA_WIDTH(DW), .EOP_CHAR(EOP),
    .MAX_PKT_LEN(MAXL), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Bytes each requester still wants to send, head is presented on req_data.
  typedef logic [7:0] bq_t[$];
  bq_t q [NREQ];

  // Reference model: owner index (-1 idle), previous winner, bytes and idle cycles in this grant, output slot.
  int         m_owner;
  int         m_last;
  int         m_nbytes;
  int         m_nidle;
  logic       m_ov;
  logic [7:0] m_od;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NREQ - 1; m_nbytes = 0; m_nidle = 0;
    m_ov = 1'b0; m_od = 8'h00;
  endtask

  function automatic logic [7:0] rand_body();
    logic [7:0] b;
    b = 8'($urandom_range(255));
    if (b == EOP) b = 8'h0B;
    return b;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic cycle(input int rdy_pct, input int vld_pct);
    logic [NREQ-1:0] exp_grant, exp_rdy;
    logic            free;
    logic [7:0]      d;
    int              win;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() > 0) && ($urandom_range(99) < vld_pct);
      req_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
    tx_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    exp_grant = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    free      = !m_ov || tx_ready;
    exp_rdy   = (m_owner >= 0 && free) ? exp_grant : '0;
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("busy", 32'(busy), 32'(m_owner >= 0));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tx_valid", 32'(tx_valid), 32'(m_ov));
    chk("tx_data", 32'(tx_data), 32'(m_od));
    if (m_ov && tx_ready) m_ov = 1'b0;
    if (m_owner < 0) begin
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (win < 0 && req_valid[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
      end
      if (win >= 0) begin
        m_owner = win; m_last = win; m_nbytes = 0; m_nidle = 0;
      end
    end else if (req_valid[m_owner] && free) begin
      d = req_data[m_owner*DW +: DW];
      void'(q[m_owner].pop_front());
      m_ov = 1'b1; m_od = d;
      m_nbytes++; m_nidle = 0;
      if (d == EOP || m_nbytes == MAXL) m_owner = -1;
    end else if (!req_valid[m_owner]) begin
      m_nidle++;
      if (m_nidle == TO) m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) n += q[i].size();
    return n;
  endfunction

  task automatic drain();
    int g = 0;
    while ((pending() > 0 || m_owner >= 0 || m_ov) && g < 3000) begin
      cycle(100, 100);
      g++;
    end
    chk("drain_bound", 32'(g < 3000), 32'(1));
  endtask

  initial begin
    int g;
    rst_n = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'(0));
    chk("rst_tx_data", 32'(tx_data), 32'(0));
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single short packet from requester 0.
    q[0].push_back(8'h41); q[0].push_back(EOP);
    drain();

    // Two and three contending requesters with two-byte packets.
    q[0].push_back(8'h50); q[0].push_back(EOP);
    q[2].push_back(8'h52); q[2].push_back(EOP);
    drain();
    q[0].push_back(8'h60); q[0].push_back(EOP);
    q[1].push_back(8'h61); q[1].push_back(EOP);
    q[3].push_back(8'h63); q[3].push_back(EOP);
    drain();

    // Long stream hits the per-grant byte limit.
    for (int i = 0; i < 70; i++) q[1].push_back(rand_body());
    drain();

    // One byte then silence: idle timeout hands over to waiting requester 0.
    q[3].push_back(8'h33);
    cycle(100, 100);
    q[0].push_back(8'h30); q[0].push_back(EOP);
    drain();

    // Transmitter stalls for 20 cycles mid-packet.
    for (int i = 0; i < 10; i++) q[2].push_back(rand_body());
    q[2].push_back(EOP);
    g = 0;
    while (m_nbytes < 3 && g < 50) begin cycle(100, 100); g++; end
    for (int i = 0; i < 20; i++) cycle(0, 100);
    drain();

    // Randomized traffic with varying readiness and valid density.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (q[i].size() == 0 && $urandom_range(99) < 10) begin
            int len = $urandom_range(80, 1);
            for (int b = 0; b < len - 1; b++) q[i].push_back(rand_body());
            q[i].push_back(($urandom_range(1) == 1) ? EOP : rand_body());
          end
        end
        case (ph)
          0: cycle(100, 100);
          1: cycle(60, 90);
          2: cycle(90, 40);
          default: cycle(30, 70);
        endcase
      end
    end
    drain();

    // Asynchronous reset in the middle of a packet.
    for (int i = 0; i < 10; i++) q[2].push_back(rand_body());
    g = 0;
    while (m_nbytes < 2 && g < 50) begin cycle(100, 100); g++; end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'(0));
    chk("arst_grant", 32'(grant), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_req_ready", 32'(req_ready), 32'(0));
    model_reset();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    req_valid = '0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    q[0].push_back(EOP); q[2].push_back(EOP);
    cycle(100, 100);
    chk("rr_after_reset", 32'(grant), 32'(4'b0001));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
